// File: rtl/myproject_sdiv_36s_9ns_33_seq_if.sv
// Block-level handshake and operand/result bundle for the iterative signed divider.
// The master issues ap_start with operands; the slave (divider) answers with ready/idle/done and results.
interface myproject_sdiv_36s_9ns_33_seq_if #(
    parameter int din0_WIDTH = 36,
    parameter int din1_WIDTH = 9,
    parameter int dout_WIDTH = 33,
    parameter int rem_WIDTH  = 10
);
    logic                  ap_start;
    logic                  ap_ready;
    logic                  ap_idle;
    logic                  ap_done;
    logic [din0_WIDTH-1:0] din0;
    logic [din1_WIDTH-1:0] din1;
    logic [dout_WIDTH-1:0] quot;
    logic [rem_WIDTH-1:0]  rem;
    logic                  ovf;
    logic                  div_zero;

    modport master (
        output ap_start, din0, din1,
        input  ap_ready, ap_idle, ap_done, quot, rem, ovf, div_zero
    );

    modport slave (
        input  ap_start, din0, din1,
        output ap_ready, ap_idle, ap_done, quot, rem, ovf, div_zero
    );
endinterface

// File: rtl/myproject_sdiv_36s_9ns_33_seq.sv
// Iterative 36-bit signed / 9-bit unsigned divider, one quotient bit per cycle,
// truncating toward zero with a saturated 33-bit quotient and a dividend-signed remainder.
module myproject_sdiv_36s_9ns_33_seq #(
    parameter int din0_WIDTH = 36,
    parameter int din1_WIDTH = 9,
    parameter int dout_WIDTH = 33,
    parameter int rem_WIDTH  = 10
) (
    input  logic                                 ap_clk,
    input  logic                                 ap_rst,
    myproject_sdiv_36s_9ns_33_seq_if.slave       bus,
    output logic [1:0]                           dbg_state
);
    localparam int CW = $clog2(din0_WIDTH);

    // Saturation limits on the unsigned magnitude: 2^(dout-1)-1 for positive, 2^(dout-1) for negative.
    localparam logic [din0_WIDTH-1:0] POS_LIM =
        {{(din0_WIDTH-dout_WIDTH+1){1'b0}}, {(dout_WIDTH-1){1'b1}}};
    localparam logic [din0_WIDTH-1:0] NEG_LIM = POS_LIM + 1'b1;
    localparam logic [dout_WIDTH-1:0] QMAX = {1'b0, {(dout_WIDTH-1){1'b1}}};
    localparam logic [dout_WIDTH-1:0] QMIN = {1'b1, {(dout_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           cnt;
    logic                    neg;
    logic [din0_WIDTH-1:0]   work;   // dividend magnitude shifting out, quotient bits shifting in
    logic [din1_WIDTH-1:0]   dvs;
    logic [din1_WIDTH-1:0]   prem;   // partial remainder, always < dvs

    logic [din0_WIDTH-1:0]   mag;
    logic [din1_WIDTH:0]     trial;
    logic [din1_WIDTH-1:0]   trial_sub;
    logic                    ge;
    logic [dout_WIDTH-1:0]   work_neg;
    logic [rem_WIDTH-1:0]    rem_neg;

    logic [dout_WIDTH-1:0]   fix_quot, quot_r;
    logic [rem_WIDTH-1:0]    fix_rem, rem_r;
    logic                    fix_ovf, fix_dz, ovf_r, dz_r;

    // Handshake: ap_start is a request sampled only in IDLE; ap_ready pulses in the accepting
    // cycle (operands captured at that edge); ap_done pulses one cycle with results valid.
    // ap_start seen in any other state is dropped, not queued.

    assign mag       = bus.din0[din0_WIDTH-1] ? (~bus.din0 + 1'b1) : bus.din0;
    assign trial     = {prem, work[din0_WIDTH-1]};
    assign ge        = (trial >= {1'b0, dvs});
    assign trial_sub = trial[din1_WIDTH-1:0] - dvs;
    assign work_neg  = ~work[dout_WIDTH-1:0] + 1'b1;
    assign rem_neg   = ~{1'b0, prem} + 1'b1;

    always_comb begin
        fix_quot = '0;
        fix_rem  = '0;
        fix_ovf  = 1'b0;
        fix_dz   = 1'b0;
        if (dvs == '0) begin
            fix_dz   = 1'b1;
            fix_quot = neg ? QMIN : QMAX;
        end else if (!neg) begin
            fix_rem = {1'b0, prem};
            if (work > POS_LIM) begin
                fix_ovf  = 1'b1;
                fix_quot = QMAX;
            end else begin
                fix_quot = work[dout_WIDTH-1:0];
            end
        end else begin
            // neg is never set for a zero dividend, so no -0 can appear here.
            fix_rem = rem_neg;
            if (work > NEG_LIM) begin
                fix_ovf  = 1'b1;
                fix_quot = QMIN;
            end else begin
                fix_quot = work_neg;
            end
        end
    end

    always_comb begin
        state_nx     = state;
        bus.ap_ready = 1'b0;
        bus.ap_idle  = 1'b0;
        bus.ap_done  = 1'b0;
        case (state)
            S_IDLE: begin
                bus.ap_idle = 1'b1;
                if (bus.ap_start) begin
                    bus.ap_ready = 1'b1;
                    state_nx     = (bus.din1 == '0) ? S_FIX : S_CALC;
                end
            end
            S_CALC: if (cnt == '0) state_nx = S_FIX;
            S_FIX:  state_nx = S_DONE;
            S_DONE: begin
                bus.ap_done = 1'b1;
                state_nx    = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            neg    <= 1'b0;
            work   <= '0;
            dvs    <= '0;
            prem   <= '0;
            quot_r <= '0;
            rem_r  <= '0;
            ovf_r  <= 1'b0;
            dz_r   <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                S_IDLE: if (bus.ap_start) begin
                    neg  <= bus.din0[din0_WIDTH-1];
                    work <= mag;
                    dvs  <= bus.din1;
                    prem <= '0;
                    cnt  <= CW'(din0_WIDTH - 1);
                end
                S_CALC: begin
                    work <= {work[din0_WIDTH-2:0], ge};
                    prem <= ge ? trial_sub : trial[din1_WIDTH-1:0];
                    if (cnt != '0) cnt <= cnt - 1'b1;
                end
                S_FIX: begin
                    quot_r <= fix_quot;
                    rem_r  <= fix_rem;
                    ovf_r  <= fix_ovf;
                    dz_r   <= fix_dz;
                end
                default: ;
            endcase
        end
    end

    assign bus.quot     = quot_r;
    assign bus.rem      = rem_r;
    assign bus.ovf      = ovf_r;
    assign bus.div_zero = dz_r;
    assign dbg_state    = state;
endmodule

// File: tb/tb_myproject_sdiv_36s_9ns_33_seq.sv
// Self-checking bench for the iterative signed divider: directed corner cases, handshake
// behaviour (back-to-back, mid-op start, mid-op reset) and a randomized sweep against a C-style model.
module tb_myproject_sdiv_36s_9ns_33_seq;
    logic       ap_clk = 1'b0;
    logic       ap_rst;
    logic [1:0] dbg_state;

    myproject_sdiv_36s_9ns_33_seq_if bus ();

    myproject_sdiv_36s_9ns_33_seq dut (
        .ap_clk    (ap_clk),
        .ap_rst    (ap_rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    always #5 ap_clk = ~ap_clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [44:0] exp_q[$];     // {quot[32:0], rem[9:0], ovf, div_zero}
    logic [32:0] last_quot;

    localparam longint QMAX_L = 64'sd4294967295;
    localparam longint QMIN_L = -64'sd4294967296;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // C-semantics reference: / and % truncate toward zero, then saturate to 33-bit signed.
    function automatic logic [44:0] model(input logic [35:0] a, input logic [8:0] b);
        longint sa, lb, qq, rr;
        logic [32:0] q;
        logic [9:0]  r;
        logic        o, z;
        sa = $signed(a);
        lb = b;
        o  = 1'b0;
        z  = 1'b0;
        if (lb == 0) begin
            z = 1'b1;
            r = '0;
            q = (sa < 0) ? 33'h1_0000_0000 : 33'h0_FFFF_FFFF;
        end else begin
            qq = sa / lb;
            rr = sa % lb;
            if (qq > QMAX_L) begin
                qq = QMAX_L;
                o  = 1'b1;
            end else if (qq < QMIN_L) begin
                qq = QMIN_L;
                o  = 1'b1;
            end
            q = qq[32:0];
            r = rr[9:0];
        end
        return {q, r, o, z};
    endfunction

    task automatic check_result(input string tag, input logic [44:0] e);
        check({tag, "_quot"}, bus.quot, e[44:12]);
        check({tag, "_rem"}, bus.rem, e[11:2]);
        check({tag, "_ovf"}, bus.ovf, e[1]);
        check({tag, "_dz"}, bus.div_zero, e[0]);
    endtask

    task automatic wait_done(output int n, output bit done);
        n    = 0;
        done = 1'b0;
        while (!done && n < 60) begin
            @(negedge ap_clk);
            n++;
            if (bus.ap_done) done = 1'b1;
        end
    endtask

    task automatic do_op(input logic [35:0] a, input logic [8:0] b, input bit pulse_mid);
        logic [44:0] e;
        int          n;
        bit          done;
        logic [31:0] r1;
        exp_q.push_back(model(a, b));
        @(negedge ap_clk);
        bus.ap_start = 1'b1;
        bus.din0     = a;
        bus.din1     = b;
        #1 check("ready_on_start", bus.ap_ready, 1);
        @(posedge ap_clk);
        #1;
        bus.ap_start = 1'b0;
        r1 = $urandom;
        bus.din0 = {r1[3:0], r1};
        bus.din1 = r1[8:0];
        n    = 0;
        done = 1'b0;
        while (!done && n < 60) begin
            @(negedge ap_clk);
            n++;
            if (bus.ap_done) done = 1'b1;
            else begin
                if (n == 20) check("hold_quot", bus.quot, last_quot);
                if (pulse_mid && n == 10) begin
                    bus.ap_start = 1'b1;
                    bus.din0     = 36'd77;
                    bus.din1     = 9'd3;
                    #1 check("ready_ignored", bus.ap_ready, 0);
                end
                if (pulse_mid && n == 11) bus.ap_start = 1'b0;
            end
        end
        check("done_seen", done, 1);
        check("latency", n, (b == 0) ? 2 : 38);
        e = exp_q.pop_front();
        check_result("op", e);
        last_quot = e[44:12];
        @(negedge ap_clk);
        check("done_pulse", bus.ap_done, 0);
        check("idle_after", bus.ap_idle, 1);
    endtask

    logic [35:0] da[10];
    logic [8:0]  db[10];

    initial begin
        logic [44:0]        e1, e2;
        int                 n;
        bit                 done;
        int                 dones;
        logic [31:0]        r1, r2;
        logic signed [35:0] t;
        logic [35:0]        a;
        logic [8:0]         b;

        ap_rst       = 1'b1;
        bus.ap_start = 1'b0;
        bus.din0     = '0;
        bus.din1     = '0;
        last_quot    = '0;
        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        check("rst_idle", bus.ap_idle, 1);
        check("rst_ready", bus.ap_ready, 0);
        check("rst_done", bus.ap_done, 0);
        check_result("rst", 45'd0);
        ap_rst = 1'b0;

        da[0] = 36'sd1000;           db[0] = 9'd7;
        da[1] = -36'sd1000;          db[1] = 9'd7;
        da[2] = 36'h8_0000_0000;     db[2] = 9'd1;
        da[3] = 36'h7_FFFF_FFFF;     db[3] = 9'd255;
        da[4] = 36'sd5;              db[4] = 9'd0;
        da[5] = 36'sd0;              db[5] = 9'd13;
        da[6] = -36'sd5;             db[6] = 9'd0;
        da[7] = -36'sh2_0000_0000;   db[7] = 9'd2;
        da[8] = 36'h1_0000_0000;     db[8] = 9'd1;
        da[9] = -36'sd123457;        db[9] = 9'd511;
        for (int i = 0; i < 10; i++) do_op(da[i], db[i], i == 3);

        // Start held high: the next op is accepted the cycle after ap_done.
        e1 = model(36'sd99999, 9'd10);
        e2 = model(-36'sd4242, 9'd100);
        @(negedge ap_clk);
        bus.ap_start = 1'b1;
        bus.din0     = 36'sd99999;
        bus.din1     = 9'd10;
        @(posedge ap_clk);
        #1;
        bus.din0 = -36'sd4242;
        bus.din1 = 9'd100;
        wait_done(n, done);
        check("b2b_first_done", done, 1);
        check("b2b_first_lat", n, 38);
        check_result("b2b_first", e1);
        @(negedge ap_clk);
        #1 check("b2b_ready", bus.ap_ready, 1);
        @(posedge ap_clk);
        #1 bus.ap_start = 1'b0;
        wait_done(n, done);
        check("b2b_second_done", done, 1);
        check("b2b_second_lat", n, 38);
        check_result("b2b_second", e2);
        last_quot = e2[44:12];

        // Reset in cycle 20 of an op aborts it and clears outputs.
        @(negedge ap_clk);
        bus.ap_start = 1'b1;
        bus.din0     = 36'sd1000;
        bus.din1     = 9'd7;
        @(posedge ap_clk);
        #1 bus.ap_start = 1'b0;
        repeat (20) @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        check("abort_idle", bus.ap_idle, 1);
        check("abort_done", bus.ap_done, 0);
        check_result("abort", 45'd0);
        ap_rst    = 1'b0;
        last_quot = '0;
        dones     = 0;
        repeat (45) begin
            @(negedge ap_clk);
            if (bus.ap_done) dones++;
        end
        check("abort_no_done", dones, 0);

        for (int i = 0; i < 700; i++) begin
            r1 = $urandom;
            r2 = $urandom;
            case ($urandom_range(0, 4))
                0: a = {r1[3:0], r2};
                1: begin
                    t = $urandom_range(0, 2000);
                    t = t - 36'sd1000;
                    a = t;
                end
                2: a = r1[0] ? 36'h8_0000_0000 : 36'h7_FFFF_FFFF;
                3: a = {r1[3], r1[3], r1[3], r2, r1[2]};
                default: a = {{4{r1[5]}}, r2};
            endcase
            case ($urandom_range(0, 5))
                0: b = 9'd0;
                1: b = 9'd1;
                2: b = 9'd511;
                3: b = $urandom_range(1, 8);
                default: b = r1[16:8];
            endcase
            do_op(a, b, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
